serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Sequencer that time-shares one 1-bit full-adder cell, built from two half adders, to add two WIDTH-bit operands bit-serially, LSB first.
//  Operands arrive on a valid/ready start interface; the result leaves on a valid/ready result interface.
//  Area-lean alternative to a ripple adder for slow-path arithmetic; one operation in flight.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range 2..32
// PORTS
//  clk          in   1      rising-edge clock, single clock domain
//  rst_n        in   1      asynchronous active-low reset
//  start_valid  in   1      operands a, b and cin valid
//  start_ready  out  1      block can accept operands (state IDLE)
//  a            in   WIDTH  operand A, sampled on start handshake
//  b            in   WIDTH  operand B, sampled on start handshake
//  cin          in   1      carry-in, sampled on start handshake
//  busy         out  1      1 in RUN or DONE
//  res_valid    out  1      sum/cout valid (state DONE)
//  res_ready    in   1      consumer accepts result
//  sum          out  WIDTH  A+B+cin modulo 2^WIDTH
//  cout         out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  - Reset, asynchronous: state=IDLE, bit counter=0, shift regs=0, carry reg=0, sum=0, cout=0, res_valid=0, busy=0.
//  - start_ready = (state==IDLE), decoded from state only, so it reads 1 during reset.
//  - FSM IDLE->RUN: start_valid & start_ready at an edge. Load a and b into shift regs, cin into carry reg, counter=0.
//  - RUN: each edge feeds shift-reg bit 0 of A, bit 0 of B and the carry reg to fa_cell.
//    * The cell's s shifts into sum from the MSB side.
//    * The cell's c is written to the carry reg.
//    * Both operand regs shift right by 1 and the counter increments.
//  - RUN->DONE on the edge that processes bit WIDTH-1 (counter==WIDTH-1). On that edge cout takes the final carry.
//  - Latency: accept on edge E0; res_valid is high in the cycle after edge E(WIDTH). Exactly WIDTH RUN cycles.
//  - DONE: res_valid=1. sum and cout are held stable until res_valid & res_ready at an edge, then DONE->IDLE.
//    No back-to-back start in that same edge; start_ready rises the next cycle.
//  - start_valid in RUN or DONE is ignored. The input bus may change freely outside IDLE.
//  - sum/cout keep their last result in IDLE and RUN, and are only meaningful while res_valid=1.
//  - res_ready with res_valid=0 has no effect.
//  - Wrap-around: sum is truncated to WIDTH bits; overflow shows only on cout.
//  - Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1.
//  - Reset asserted mid-RUN or mid-DONE aborts the operation. The partial result is discarded; all registers take reset values.
//  - No X on any output after reset, whatever the inputs.
// STRUCTURE
//  - Package serial_add_pkg holds:
//    * typedef enum logic [1:0] {ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2} sadd_state_t
//    * localparam DEFAULT_WIDTH = 8
//  - Sub-module fa_cell (a, b, ci -> s, co) is two half-adder instances plus an OR of their carries.
//    It is the only arithmetic in the block; the controller has no '+' operator.
//  - The top holds the FSM, counter, two operand shift regs, carry reg and sum shift reg.
// TESTING (WIDTH=8 unless stated)
//  1. a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0; res_valid rises exactly 8 cycles after accept; busy=1 throughout.
//  2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
//  3. Backpressure: res_ready held 0 for 5 cycles in DONE -> sum/cout/res_valid stable, start_ready=0;
//     res_ready=1 -> IDLE next cycle, start_ready=1.
//  4. start_valid pulsed with new operands during RUN -> ignored; the result matches the original operands.
//  5. rst_n low for 1 cycle after 3 bits processed -> all outputs 0 and IDLE immediately;
//     a fresh op 0x01+0x01 then gives sum=0x02, cout=0.
//  6. WIDTH=2, all 32 combinations of a, b and cin -> sum/cout match the reference model; 3 back-to-back ops with res_ready tied 1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
// The counter step is built from XOR/AND gates so that fa_cell remains the only adder.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sadd_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Gate-level increment: a half-adder chain with the carry-in tied to 1.
  function automatic logic [31:0] count_up(input logic [31:0] v);
    logic [31:0] r;
    logic        c;
    c = 1'b1;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[i] ^ c;
      c    = v[i] & c;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start and result handshake bundle for serial_add_ctrl.
// The master modport is the requester/consumer side; the slave modport is the adder side.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start_valid, a, b, cin, res_ready,
    input  start_ready, busy, res_valid, sum, cout
  );

  modport slave (
    input  start_valid, a, b, cin, res_ready,
    output start_ready, busy, res_valid, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder built from two half adders.
// The final carry is the OR of the two half-adder carries, which can never both be 1.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: a single fa_cell processes one bit per clock, LSB first.
// Only one operation is in flight at a time, with valid/ready handshakes on both sides.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sadd_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             res_valid_q;
  logic             busy_q;

  logic             fa_s;
  logic             fa_c;
  logic [CNT_W-1:0] cnt_d;

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  assign cnt_d = CNT_W'(count_up(32'(cnt_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at index 0.
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          carry_q <= fa_c;
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          if (cnt_q == LAST_BIT) begin
            cnt_q       <= '0;
            cout_q      <= fa_c;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Decoded from the state alone, so it also reads 1 while reset is held.
  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.busy        = busy_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.sum         = sum_q;
  assign bus.cout        = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance driven from a vector table and
// hand-written corner sequences, plus a 2-bit instance swept through every input combination.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;

  serial_add_ctrl_if #(.WIDTH(8)) if8 ();
  serial_add_ctrl_if #(.WIDTH(2)) if2 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_add_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    if8.a           = a;
    if8.b           = b;
    if8.cin         = c;
    if8.start_valid = 1'b1;
    @(posedge clk);
    #1;
    if8.start_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until res_valid; flags any cycle with busy low.
  task automatic wait_done8(output int cyc, output logic busy_ok);
    cyc     = 0;
    busy_ok = 1'b1;
    while (!if8.res_valid && cyc < 64) begin
      if (if8.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (if8.busy !== 1'b1) busy_ok = 1'b0;
  endtask

  task automatic drain8;
    if8.res_ready = 1'b1;
    @(posedge clk);
    #1;
    if8.res_ready = 1'b0;
  endtask

  task automatic do_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] exp_s, input logic exp_c);
    int   lat;
    logic bok;
    start8(a, b, c);
    wait_done8(lat, bok);
    check({tag, " sum"},     32'(if8.sum),  32'(exp_s));
    check({tag, " cout"},    32'(if8.cout), 32'(exp_c));
    check({tag, " latency"}, 32'(lat),      32'd8);
    check({tag, " busy"},    32'(bok),      32'd1);
    $display("op8 %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d lat=%0d",
             tag, a, b, c, if8.sum, if8.cout, lat);
    drain8();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int         lat;
    logic       bok;
    logic [2:0] ref2;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    if8.start_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.res_ready = 1'b0;
    if2.start_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0; if2.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst start_ready", 32'(if8.start_ready), 32'd1);
    check("rst busy",        32'(if8.busy),        32'd0);
    check("rst res_valid",   32'(if8.res_valid),   32'd0);
    check("rst sum",         32'(if8.sum),         32'd0);
    check("rst cout",        32'(if8.cout),        32'd0);
    check("rst w2 res_valid", 32'(if2.res_valid),  32'd0);
    $display("reset: start_ready=%0d busy=%0d res_valid=%0d sum=%02h cout=%0d",
             if8.start_ready, if8.busy, if8.res_valid, if8.sum, if8.cout);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
    end

    // Backpressure: result must stay put while the consumer stalls.
    start8(8'h5A, 8'h3C, 1'b0);
    wait_done8(lat, bok);
    check("bp latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d sum", i),         32'(if8.sum),         32'h96);
      check($sformatf("bp%0d cout", i),        32'(if8.cout),        32'd0);
      check($sformatf("bp%0d res_valid", i),   32'(if8.res_valid),   32'd1);
      check($sformatf("bp%0d start_ready", i), 32'(if8.start_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    drain8();
    check("bp after res_valid",   32'(if8.res_valid),   32'd0);
    check("bp after start_ready", 32'(if8.start_ready), 32'd1);
    check("bp after busy",        32'(if8.busy),        32'd0);
    $display("backpressure: held 5 cycles, released -> start_ready=%0d", if8.start_ready);

    // New operands offered mid-RUN must be ignored.
    start8(8'h11, 8'h22, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; if8.start_valid = 1'b1;
    repeat (2) @(negedge clk);
    if8.start_valid = 1'b0;
    wait_done8(lat, bok);
    check("ignore sum",  32'(if8.sum),  32'h33);
    check("ignore cout", 32'(if8.cout), 32'd0);
    check("ignore busy", 32'(bok),      32'd1);
    $display("ignore-start: sum=%02h cout=%0d", if8.sum, if8.cout);
    drain8();

    // Asynchronous reset after three bits have been processed.
    start8(8'hAA, 8'h55, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort start_ready", 32'(if8.start_ready), 32'd1);
    check("abort busy",        32'(if8.busy),        32'd0);
    check("abort res_valid",   32'(if8.res_valid),   32'd0);
    check("abort sum",         32'(if8.sum),         32'd0);
    check("abort cout",        32'(if8.cout),        32'd0);
    $display("abort: busy=%0d res_valid=%0d sum=%02h", if8.busy, if8.res_valid, if8.sum);
    @(negedge clk);
    rst_n = 1'b1;
    do_op8("post-abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // WIDTH=2 sweep, consumer always ready, ops issued back to back.
    if2.res_ready = 1'b1;
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          ref2 = 3'(ai) + 3'(bi) + 3'(ci);
          @(negedge clk);
          if2.a = 2'(ai); if2.b = 2'(bi); if2.cin = 1'(ci); if2.start_valid = 1'b1;
          @(posedge clk);
          #1;
          if2.start_valid = 1'b0;
          lat = 0;
          while (!if2.res_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
          end
          check($sformatf("w2 %0d+%0d+%0d sum", ai, bi, ci),  32'(if2.sum),  32'(ref2[1:0]));
          check($sformatf("w2 %0d+%0d+%0d cout", ai, bi, ci), 32'(if2.cout), 32'(ref2[2]));
          $display("op2: a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d lat=%0d",
                   ai, bi, ci, if2.sum, if2.cout, lat);
          @(posedge clk);
          #1;
        end
      end
    end
    check("w2 lat last", 32'(lat), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
